// File: rtl/if_prefetch_unit_if.sv
// Bundle of the instruction-fetch front end's bus signals.
//   imem_*     : request/acknowledge handshake to instruction memory
//   redirect_* : branch redirect from EX
//   stall      : hazard-unit hold for decode
//   inst_*     : FIFO head presented to decode
//   halted     : halt word fetched, fetching stopped
//   pc_out     : next fetch address (debug)
// master = the prefetch unit, slave = its environment (memory, EX, decode).
interface if_prefetch_unit_if #(
  parameter int ADDR_W = 10
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              stall;
  logic              inst_valid;
  logic [31:0]       inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic              halted;
  logic [ADDR_W-1:0] pc_out;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc, halted, pc_out,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, halted, pc_out,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, stall
  );
endinterface

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end for the 5-stage MIPS pipeline.
// Owns the word-addressed PC, issues one request at a time to instruction
// memory, buffers returned words in a small prefetch FIFO and presents one
// instruction per cycle to decode. Branch redirects flush the FIFO and drop
// any in-flight response; fetching stops once HALT_WORD has been fetched.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : if_prefetch_unit_if.master (memory handshake, redirect, stall,
//          decode-side instruction, halted, pc_out)
module if_prefetch_unit #(
  parameter int              ADDR_W    = 10,
  parameter int              DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     HALT_WORD = 32'h0000_0001
) (
  input logic               clk,
  input logic               rst,
  if_prefetch_unit_if.master bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD,
    S_HALT
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;

  logic [31:0]       fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  logic fifo_valid;
  logic req;
  logic pop;
  logic push;
  logic flush;

  assign fifo_valid = (count != '0);
  assign pop        = fifo_valid && !bus.stall;

  // A fresh request is only raised from IDLE with room left; since at most
  // one request is ever outstanding, count < DEPTH guarantees the eventual
  // push fits even if decode is stalled meanwhile.
  assign req = !rst && (((state == S_IDLE) && (count < CNT_FULL)) ||
                        (state == S_WAIT));

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    push     = 1'b0;
    flush    = 1'b0;

    if (state != S_HALT) begin
      if (bus.redirect_valid) begin
        flush = 1'b1;
        pc_nx = bus.redirect_pc;
        // A request already visible to memory must have its ack swallowed;
        // an ack in this same cycle completes it, so nothing is left pending.
        if (state == S_DISCARD)
          state_nx = bus.imem_ack ? S_IDLE : S_DISCARD;
        else
          state_nx = (req && !bus.imem_ack) ? S_DISCARD : S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_WAIT: begin
            if (req) begin
              if (bus.imem_ack) begin
                push     = 1'b1;
                pc_nx    = pc + 1'b1;
                state_nx = (bus.imem_rdata == HALT_WORD) ? S_HALT : S_IDLE;
              end else begin
                state_nx = S_WAIT;
              end
            end
          end
          S_DISCARD: begin
            if (bus.imem_ack) state_nx = S_IDLE;
          end
          default: state_nx = state;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only observed through count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_data[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr]   <= pc;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = fifo_valid;
  assign bus.inst_out   = fifo_valid ? fifo_data[rd_ptr] : '0;
  assign bus.inst_pc    = fifo_valid ? fifo_pc[rd_ptr] : '0;
  assign bus.halted     = (state == S_HALT);
  assign bus.pc_out     = pc;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Self-checking bench for if_prefetch_unit: a behavioural memory with
// variable latency, a queue-based reference model of the fetch unit, a
// per-cycle comparison of every output, and directed scenarios with
// hand-computed literal expectations.
module tb_if_prefetch_unit;
  localparam int          ADDR_W    = 10;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] HALT_WORD = 32'h0000_0001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_prefetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  if_prefetch_unit #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC ('0),
    .HALT_WORD(HALT_WORD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: delivered instructions as a queue of {pc, word}.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       data;
  } entry_t;

  entry_t            mq[$];
  logic [ADDR_W-1:0] m_pc;
  bit                m_out;   // request issued, waiting for its ack
  bit                m_disc;  // stale request whose ack must be dropped
  bit                m_halt;
  bit                exp_req;

  // Memory behaviour
  bit                mem_busy;
  int                mem_cnt;
  logic [ADDR_W-1:0] mem_a;
  int                lat_mode;  // <0 : random 0..3 cycles
  bit                halt_en;
  bit                saw_addr6;

  logic              last_req;
  logic [ADDR_W-1:0] last_addr;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    if (halt_en && a == ADDR_W'(5)) return HALT_WORD;
    return 32'(a) + 32'd100;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc   = '0;
    m_out  = 1'b0;
    m_disc = 1'b0;
    m_halt = 1'b0;
  endtask

  task automatic mem_drive();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    if (rst) begin
      mem_busy = 1'b0;
      return;
    end
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(mem_a);
        mem_busy       = 1'b0;
      end
    end else if (bus.imem_req) begin
      mem_a   = bus.imem_addr;
      mem_cnt = (lat_mode < 0) ? int'($urandom_range(3)) : lat_mode;
      if (mem_cnt == 0) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(mem_a);
      end else begin
        mem_busy = 1'b1;
      end
    end
  endtask

  task automatic compare_now();
    logic [31:0] e_out;
    logic [ADDR_W-1:0] e_pc;
    exp_req = !rst && !m_halt && !m_disc && (m_out || mq.size() < DEPTH);
    e_out = (mq.size() > 0) ? mq[0].data : 32'h0;
    e_pc  = (mq.size() > 0) ? mq[0].pc : '0;
    check("imem_req", 32'(bus.imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
    check("inst_valid", 32'(bus.inst_valid), 32'(mq.size() > 0));
    check("inst_out", bus.inst_out, e_out);
    check("inst_pc", 32'(bus.inst_pc), 32'(e_pc));
    check("halted", 32'(bus.halted), 32'(m_halt));
    check("pc_out", 32'(bus.pc_out), 32'(m_pc));
    last_req  = bus.imem_req;
    last_addr = bus.imem_addr;
    if (halt_en && bus.imem_req && bus.imem_addr == ADDR_W'(6)) saw_addr6 = 1'b1;
  endtask

  task automatic model_step(input bit r, input bit st, input bit rv,
                            input logic [ADDR_W-1:0] rp, input bit ak,
                            input logic [31:0] rd);
    entry_t e;
    if (r) begin
      model_reset();
      return;
    end
    if (m_halt) begin
      if (mq.size() > 0 && !st) void'(mq.pop_front());
      return;
    end
    if (rv) begin
      mq.delete();
      m_pc = rp;
      if (m_disc) m_disc = !ak;
      else        m_disc = exp_req && !ak;
      m_out = 1'b0;
      return;
    end
    if (mq.size() > 0 && !st) void'(mq.pop_front());
    if (m_disc) begin
      if (ak) m_disc = 1'b0;
    end else if (exp_req) begin
      if (ak) begin
        e.pc   = m_pc;
        e.data = rd;
        mq.push_back(e);
        m_pc  = m_pc + 1'b1;
        m_out = 1'b0;
        if (rd == HALT_WORD) m_halt = 1'b1;
      end else begin
        m_out = 1'b1;
      end
    end
  endtask

  // One clock cycle: drive inputs, let memory respond, compare, clock the model.
  task automatic tick(input bit r, input bit st, input bit rv, input logic [ADDR_W-1:0] rp);
    bit          ak;
    logic [31:0] rd;
    rst                = r;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    #1;
    mem_drive();
    #1;
    compare_now();
    ak = bus.imem_ack;
    rd = bus.imem_rdata;
    @(posedge clk);
    model_step(r, st, rv, rp, ak, rd);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    halt_en   = 1'b0;
    lat_mode  = 0;
    saw_addr6 = 1'b0;
    mem_busy  = 1'b0;
    model_reset();

    // Reset
    tick(1, 0, 0, '0);
    tick(1, 0, 0, '0);
    check("rst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_pc_out", 32'(bus.pc_out), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_req", 32'(bus.imem_req), 32'd0);

    // Linear fetch, zero-wait memory
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, '0);
      check("lin_addr", 32'(last_addr), 32'(i));
      check("lin_out", bus.inst_out, 32'(100 + i));
      check("lin_pc", 32'(bus.inst_pc), 32'(i));
    end

    // Stall 8 cycles: FIFO fills to DEPTH, head held
    for (int i = 0; i < 8; i++) tick(0, 1, 0, '0);
    check("stall_head", bus.inst_out, 32'd104);
    check("stall_req_full", 32'(bus.imem_req), 32'd0);
    check("stall_pc_out", 32'(bus.pc_out), 32'd8);
    for (int k = 1; k <= 4; k++) begin
      tick(0, 0, 0, '0);
      check("release_out", bus.inst_out, 32'(104 + k));
    end

    // Redirect while waiting on a 3-cycle memory
    lat_mode = 3;
    for (int n = 0; n < 20 && !m_out; n++) tick(0, 0, 0, '0);
    check("wait_reached", 32'(m_out), 32'd1);
    tick(0, 0, 1, ADDR_W'('h200));
    check("redir_flush", 32'(bus.inst_valid), 32'd0);
    check("redir_pc_out", 32'(bus.pc_out), 32'h200);
    for (int n = 0; n < 20 && !bus.imem_req; n++) tick(0, 0, 0, '0);
    check("redir_req", 32'(bus.imem_req), 32'd1);
    check("redir_addr", 32'(bus.imem_addr), 32'h200);
    for (int n = 0; n < 20 && !bus.inst_valid; n++) tick(0, 0, 0, '0);
    check("redir_first_pc", 32'(bus.inst_pc), 32'h200);
    check("redir_first_out", bus.inst_out, 32'h264);

    // Redirect with a same-cycle ack and two entries buffered
    lat_mode = 0;
    for (int n = 0; n < 20 && mq.size() != 2; n++) tick(0, 1, 0, '0);
    check("fill2_valid", 32'(bus.inst_valid), 32'd1);
    tick(0, 0, 1, ADDR_W'('h300));
    check("ra_flush", 32'(bus.inst_valid), 32'd0);
    tick(0, 0, 0, '0);
    check("ra_req", 32'(last_req), 32'd1);
    check("ra_addr", 32'(last_addr), 32'h300);
    check("ra_first_pc", 32'(bus.inst_pc), 32'h300);
    check("ra_first_out", bus.inst_out, 32'h364);

    // Randomised traffic
    lat_mode = -1;
    for (int i = 0; i < 400; i++) begin
      tick(0, ($urandom_range(9) < 3), ($urandom_range(19) == 0), ADDR_W'($urandom));
    end

    // Halt word at address 5
    halt_en = 1'b1;
    tick(0, 0, 1, '0);
    for (int n = 0; n < 60 && !(bus.inst_valid && bus.inst_out == HALT_WORD); n++)
      tick(0, 0, 0, '0);
    check("halt_inst", bus.inst_out, HALT_WORD);
    check("halt_inst_pc", 32'(bus.inst_pc), 32'd5);
    check("halt_flag", 32'(bus.halted), 32'd1);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, ADDR_W'('h50));
    check("halt_ignore_redir", 32'(bus.pc_out), 32'd6);
    check("halt_no_req", 32'(bus.imem_req), 32'd0);
    check("halt_still", 32'(bus.halted), 32'd1);
    check("halt_no_addr6", 32'(saw_addr6), 32'd0);

    // Reset leaves HALT
    tick(1, 0, 0, '0);
    halt_en = 1'b0;
    check("rst2_halted", 32'(bus.halted), 32'd0);

    // PC wrap at 2^ADDR_W
    lat_mode = 0;
    tick(0, 1, 1, ADDR_W'('h3FE));
    tick(0, 1, 0, '0);
    check("wrap_addr0", 32'(last_addr), 32'h3FE);
    tick(0, 1, 0, '0);
    check("wrap_addr1", 32'(last_addr), 32'h3FF);
    tick(0, 1, 0, '0);
    check("wrap_addr2", 32'(last_addr), 32'h000);
    check("wrap_pc_out", 32'(bus.pc_out), 32'd1);
    check("wrap_head_pc", 32'(bus.inst_pc), 32'h3FE);

    // Reset in the middle of a wait
    lat_mode = 3;
    tick(0, 1, 0, '0);
    tick(0, 1, 0, '0);
    tick(1, 1, 0, '0);
    check("rstw_pc_out", 32'(bus.pc_out), 32'd0);
    check("rstw_valid", 32'(bus.inst_valid), 32'd0);
    for (int i = 0; i < 10; i++) tick(0, 0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the decode stage in the 5-stage MIPS pipeline.
- Owns the word-addressed PC and issues requests to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO and presents one instruction per cycle to decode, honouring the hazard-unit stall.
- Handles branch redirects by flushing the FIFO and dropping in-flight responses, and stops fetching after the halt word.

Parameters:
ADDR_W, 10, PC / instruction-memory word-address width
DEPTH, 4, prefetch FIFO entries (power of two, >= 2)
RESET_PC, 0, PC value loaded on reset
HALT_WORD, 32'h00000001, instruction encoding that terminates fetch

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  word address of the request; stable while imem_req is high
imem_ack  in  1  memory returns imem_rdata this cycle; completes the request
imem_rdata  in  32  instruction word, valid when imem_ack
redirect_valid  in  1  branch taken in EX; flush and refetch
redirect_pc  in  ADDR_W  branch target
stall  in  1  decode cannot accept (hazard unit); hold output
inst_valid  out  1  FIFO head is valid
inst_out  out  32  FIFO head instruction; 32'h0 (NOP) when !inst_valid
inst_pc  out  ADDR_W  PC of inst_out; 0 when !inst_valid
halted  out  1  HALT_WORD has been fetched; no further requests
pc_out  out  ADDR_W  next address to be fetched (debug)

Behaviour:
- Reset, synchronous: PC = RESET_PC, FIFO count = 0, state = IDLE, halted = 0. All outputs drop to 0 in the cycle after the rst edge. rst overrides every other input, including mid-request; an ack arriving while rst is high is ignored.
- FSM states:
  - IDLE: imem_req = 1 when !halted and count < DEPTH. Go to WAIT on the same edge the request is raised unless imem_ack is already high; a zero-wait ack completes in IDLE.
  - WAIT: hold imem_req = 1 and imem_addr = PC until imem_ack.
  - DISCARD: imem_req = 0; wait for the ack of the stale request and drop its data.
  - HALT: imem_req = 0 permanently until rst.
- Handshake:
  - At most one outstanding request.
  - On an accepted ack (not discarded): push {PC, imem_rdata} and set PC = PC + 1, modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0).
  - Next state is IDLE, or HALT if imem_rdata == HALT_WORD. The halt word itself is pushed and delivered; halted is set on that edge.
- Issue throttle: a new request is raised only when count + outstanding < DEPTH, so a push never overflows.
- FIFO:
  - Registered; an entry pushed at edge N is visible on inst_out from cycle N+1, giving ack-to-decode latency of 1 cycle.
  - Pop when inst_valid && !stall.
  - Push and pop on the same edge are allowed at any count, including full after a pop.
  - Pop on empty is a no-op.
- Stall: inst_out, inst_pc and inst_valid are held unchanged while stall is high; fetch continues until the FIFO is full.
- Redirect, when redirect_valid is high and state != HALT:
  - Clear the FIFO (count = 0) and set PC = redirect_pc; inst_valid = 0 next cycle.
  - With a request outstanding and no ack this cycle, go to DISCARD.
  - With an ack in the same cycle, drop that data and go to IDLE.
  - With no request outstanding, go to IDLE.
  - The new request is issued at the earliest one cycle after redirect.
- Simultaneous events:
  - Redirect and pop on the same edge: the flush wins.
  - Redirect and halt-word ack on the same edge: the halt word is discarded and halted stays 0.
  - A redirect during DISCARD updates PC again and stays in DISCARD.
- HALT: redirect_valid is ignored; the FIFO drains normally to decode.

Test Plan:
- Linear fetch, 0-wait memory returning mem[a] = a+100 after reset -> imem_addr 0,1,2,...; inst_out 100,101,... on consecutive cycles starting 1 cycle after the first ack; inst_pc tracks 0,1,2.
- stall held 8 cycles with DEPTH=4 -> exactly 4 entries pushed, imem_req low while full; on release, entries delivered in order with no loss or duplication.
- 3-cycle memory latency with redirect_valid=1, redirect_pc=0x200 during WAIT -> stale ack dropped, FIFO empty, next imem_addr = 0x200, first inst_pc = 0x200.
- Redirect and ack in the same cycle, with the FIFO holding 2 entries -> both entries and the acked word discarded; next request is to redirect_pc.
- Memory returns 32'h00000001 at address 5 -> instruction delivered with inst_pc=5, halted=1, no request ever to address 6; a later redirect has no effect.
- PC starting at 0x3FE with ADDR_W=10 -> fetch sequence 0x3FE, 0x3FF, 0x000; then rst asserted mid-WAIT -> PC=0 and the FIFO empty on the next cycle.
